// File: rtl/arc_tg_vector_pkg.sv
// rtl/arc_tg_vector_pkg.sv - shared types, CORDIC gain and arctangent table for arc_tg_vector
package arc_tg_vector_pkg;

  typedef enum logic [1:0] {IDLE, PRE, ITER, DONE} arc_tg_state_t;

  // Fractional bits carried below the x/y integer range and below the output angle LSB
  localparam int GUARD_BITS = 10;

  // 1/K for the CORDIC gain, Q1.15
  localparam logic [15:0] CORDIC_INV_GAIN = 16'd19898;

  // atan(2^-i) as a binary angle with pi == 2^31
  localparam logic [31:0] ATAN_TABLE [32] = '{
    32'd536870912, 32'd316933406, 32'd167458907, 32'd85004756,
    32'd42667331,  32'd21354465,  32'd10679838,  32'd5340245,
    32'd2670163,   32'd1335087,   32'd667544,    32'd333772,
    32'd166886,    32'd83443,     32'd41722,     32'd20861,
    32'd10430,     32'd5215,      32'd2608,      32'd1304,
    32'd652,       32'd326,       32'd163,       32'd81,
    32'd41,        32'd20,        32'd10,        32'd5,
    32'd3,         32'd1,         32'd1,         32'd0
  };

  // atan(2^-i) rescaled to a w-bit binary angle (pi == 2^(w-1)), rounded
  function automatic logic [31:0] atan_angle(input logic [4:0] i, input int unsigned w);
    logic [32:0] r;
    if (w >= 32) return ATAN_TABLE[i];
    r = {1'b0, ATAN_TABLE[i]} + (33'd1 << (31 - w));
    return 32'(r >> (32 - w));
  endfunction

endpackage

// File: rtl/arc_tg_vector_cordic_micro_rotation.sv
// rtl/arc_tg_vector_cordic_micro_rotation.sv - one combinational CORDIC vectoring micro-rotation
module arc_tg_vector_cordic_micro_rotation
  import arc_tg_vector_pkg::*;
#(
  parameter int XW = 28,
  parameter int ZW = 26,
  parameter int SW = 4
) (
  input  logic signed [XW-1:0] x_i,
  input  logic signed [XW-1:0] y_i,
  input  logic        [ZW-1:0] z_i,
  input  logic        [SW-1:0] shift_i,
  output logic signed [XW-1:0] x_o,
  output logic signed [XW-1:0] y_o,
  output logic        [ZW-1:0] z_o
);

  logic signed [XW-1:0] x_sh;
  logic signed [XW-1:0] y_sh;
  logic        [ZW-1:0] atan_z;

  assign x_sh   = x_i >>> shift_i;
  assign y_sh   = y_i >>> shift_i;
  assign atan_z = ZW'(atan_angle(5'(shift_i), ZW));

  // Rotate toward y == 0; z accumulates the angle rotated away
  always_comb begin
    if (y_i[XW-1]) begin
      x_o = x_i - y_sh;
      y_o = y_i + x_sh;
      z_o = z_i - atan_z;
    end else begin
      x_o = x_i + y_sh;
      y_o = y_i - x_sh;
      z_o = z_i + atan_z;
    end
  end

endmodule

// File: rtl/arc_tg_vector.sv
// rtl/arc_tg_vector.sv - iterative CORDIC atan2 engine with tagged valid/ready samples
// Optional out_mag port and gain-corrected magnitude under ARC_TG_MAGNITUDE_OUT_EN.
module arc_tg_vector
  import arc_tg_vector_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ITERATIONS = 14,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_x,
  input  logic signed [DATA_WIDTH-1:0] in_y,
  input  logic        [TAG_WIDTH-1:0]  in_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_angle,
  output logic        [TAG_WIDTH-1:0]  out_tag
`ifdef ARC_TG_MAGNITUDE_OUT_EN
  ,
  output logic        [DATA_WIDTH-1:0] out_mag
`endif
);

  localparam int XW = DATA_WIDTH + 2 + GUARD_BITS;
  localparam int ZW = DATA_WIDTH + GUARD_BITS;
  localparam int CW = $clog2(DATA_WIDTH);

  arc_tg_state_t              state_q, state_d;
  logic signed [XW-1:0]       x_q, x_d, y_q, y_d, x_nx, y_nx;
  logic        [ZW-1:0]       z_q, z_d, z_nx;
  logic        [CW-1:0]       iter_q, iter_d;
  logic        [TAG_WIDTH-1:0] tag_q, tag_d, otag_q, otag_d;
  logic        [DATA_WIDTH-1:0] angle_q, angle_d, angle_rnd;
  logic                       zero_q, zero_d;
  logic                       run_q;
  logic                       last_iter;

  arc_tg_vector_cordic_micro_rotation #(.XW(XW), .ZW(ZW), .SW(CW)) u_rot (
    .x_i     (x_q),
    .y_i     (y_q),
    .z_i     (z_q),
    .shift_i (iter_q),
    .x_o     (x_nx),
    .y_o     (y_nx),
    .z_o     (z_nx)
  );

  assign last_iter = (state_q == ITER) && (iter_q == CW'(ITERATIONS - 1));
  assign angle_rnd = DATA_WIDTH'((z_nx + ZW'(1 << (GUARD_BITS - 1))) >> GUARD_BITS);
  assign in_ready  = run_q && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_angle = angle_q;
  assign out_tag   = otag_q;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    iter_d  = iter_q;
    tag_d   = tag_q;
    zero_d  = zero_q;
    angle_d = angle_q;
    otag_d  = otag_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          x_d     = XW'(in_x) <<< GUARD_BITS;
          y_d     = XW'(in_y) <<< GUARD_BITS;
          tag_d   = in_tag;
          state_d = PRE;
        end
      end
      PRE: begin
        // Fold the left half-plane onto the right by a pi rotation
        zero_d = (x_q == '0) && (y_q == '0);
        iter_d = '0;
        if (x_q[XW-1]) begin
          x_d = -x_q;
          y_d = -y_q;
          z_d = {1'b1, {(ZW-1){1'b0}}};
        end else begin
          z_d = '0;
        end
        state_d = ITER;
      end
      ITER: begin
        x_d    = x_nx;
        y_d    = y_nx;
        z_d    = z_nx;
        iter_d = iter_q + 1'b1;
        if (last_iter) begin
          angle_d = zero_q ? '0 : angle_rnd;
          otag_d  = tag_q;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      iter_q  <= '0;
      tag_q   <= '0;
      zero_q  <= 1'b0;
      angle_q <= '0;
      otag_q  <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      iter_q  <= iter_d;
      tag_q   <= tag_d;
      zero_q  <= zero_d;
      angle_q <= angle_d;
      otag_q  <= otag_d;
      run_q   <= 1'b1;
    end
  end

`ifdef ARC_TG_MAGNITUDE_OUT_EN
  localparam int PW = XW + 17;

  logic signed [PW-1:0]         mag_prod, mag_rnd;
  logic        [DATA_WIDTH-1:0] mag_sat, mag_q;

  assign mag_prod = PW'(x_nx) * PW'($signed({1'b0, CORDIC_INV_GAIN}));
  assign mag_rnd  = (mag_prod + (PW'(1) << (14 + GUARD_BITS))) >>> (15 + GUARD_BITS);

  always_comb begin
    if (mag_rnd[PW-1])                    mag_sat = '0;
    else if (|mag_rnd[PW-2:DATA_WIDTH])   mag_sat = '1;
    else                                  mag_sat = mag_rnd[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n)       mag_q <= '0;
    else if (last_iter) mag_q <= zero_q ? '0 : mag_sat;
  end

  assign out_mag = mag_q;
`endif

endmodule

// File: tb/tb_arc_tg_vector.sv
// tb/tb_arc_tg_vector.sv - randomized and directed self-checking bench for arc_tg_vector
module tb_arc_tg_vector;

  localparam int DW = 16;
  localparam int IT = 14;
  localparam int TW = 4;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_x;
  logic signed [DW-1:0] in_y;
  logic        [TW-1:0] in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic        [DW-1:0] out_angle;
  logic        [TW-1:0] out_tag;
`ifdef ARC_TG_MAGNITUDE_OUT_EN
  logic        [DW-1:0] out_mag;
`endif

  int n_vec = 0;
  int n_bad = 0;

  arc_tg_vector #(.DATA_WIDTH(DW), .ITERATIONS(IT), .TAG_WIDTH(TW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_angle (out_angle),
    .out_tag   (out_tag)
`ifdef ARC_TG_MAGNITUDE_OUT_EN
    ,
    .out_mag   (out_mag)
`endif
  );

  always #5 clk = ~clk;

  // tol > 0 compares modulo 2^16 so angles near the +-pi seam are judged correctly
  task automatic check_val(input string tag, input int got, input int exp, input int tol);
    int  d;
    logic bad;
    n_vec++;
    if (tol == 0) begin
      bad = (got != exp);
    end else begin
      d = (got - exp) & 32'hFFFF;
      if (d >= 32768) d -= 65536;
      bad = (d > tol) || (d < -tol);
    end
    if (bad) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) tol %0d", tag, got, got, exp, exp, tol);
    end
  endtask

  function automatic int ref_angle(input int x, input int y);
    real a;
    if (x == 0 && y == 0) return 0;
    a = $atan2(real'(y), real'(x)) * 32768.0 / 3.14159265358979323846;
    return $rtoi(a + ((a >= 0.0) ? 0.5 : -0.5)) & 32'hFFFF;
  endfunction

  function automatic int ref_mag(input int x, input int y);
    return $rtoi($sqrt(real'(x) * real'(x) + real'(y) * real'(y)) + 0.5);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_sample(input int x, input int y, input int tag, input int exp_ang,
                            input int tol, input int hold);
    int n;
    int viol;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check_val("in_ready_before_send", int'(in_ready), 1, 0);
    in_valid = 1'b1;
    in_x     = 16'(x);
    in_y     = 16'(y);
    in_tag   = 4'(tag);
    tick();
    n = 1;
    // Keep offering junk while busy; the engine must ignore it
    in_x   = 16'($urandom);
    in_y   = 16'($urandom);
    in_tag = 4'($urandom);
    while (!out_valid && n < 40) begin
      tick();
      n++;
      in_x   = 16'($urandom);
      in_y   = 16'($urandom);
      in_tag = 4'($urandom);
    end
    in_valid = 1'b0;
    check_val("latency", n, IT + 2, 0);
    check_val("angle", int'(out_angle), exp_ang, tol);
    check_val("tag", int'(out_tag), tag, 0);
`ifdef ARC_TG_MAGNITUDE_OUT_EN
    check_val("mag", int'(out_mag), ref_mag(x, y), (x == 0 && y == 0) ? 0 : 3);
`endif
    if (hold > 0) begin
      viol = 0;
      for (int k = 0; k < hold; k++) begin
        tick();
        if (!out_valid || in_ready || int'(out_tag) != tag) viol++;
        if (((int'(out_angle) - exp_ang + 65536 + tol) & 32'hFFFF) > 2 * tol) viol++;
      end
      check_val("hold_stable", viol, 0, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_val("in_ready_after_accept", int'(in_ready), 1, 0);
    check_val("out_valid_after_accept", int'(out_valid), 0, 0);
  endtask

  int dx  [9] = '{1000, 0,     0,      1000,  -1000,  -1000,  -32768, 3000,  0};
  int dy  [9] = '{0,    1000,  -1000,  1000,  0,      -1,     -32768, 4000,  0};
  int dex [9] = '{0,    16'h4000, 16'hC000, 16'h2000, 16'h8000, 16'h800A, 16'hA000, 16'h25C8, 0};
  int dtol[9] = '{2,    2,     2,      2,     2,      2,      2,      2,     0};

  initial begin
    int rx, ry, seen;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_x      = '0;
    in_y      = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    repeat (3) tick();
    check_val("rst_in_ready", int'(in_ready), 0, 0);
    check_val("rst_out_valid", int'(out_valid), 0, 0);
    check_val("rst_angle", int'(out_angle), 0, 0);
    check_val("rst_tag", int'(out_tag), 0, 0);
`ifdef ARC_TG_MAGNITUDE_OUT_EN
    check_val("rst_mag", int'(out_mag), 0, 0);
`endif
    reset_n = 1'b1;
    tick();
    check_val("in_ready_after_release", int'(in_ready), 1, 0);

    for (int i = 0; i < 9; i++)
      run_sample(dx[i], dy[i], (i + 5) % 16, dex[i], dtol[i], (i == 0) ? 20 : 0);

    // Reset during the iteration phase discards the sample in flight
    in_valid = 1'b1;
    in_x     = 16'sd500;
    in_y     = 16'sd700;
    in_tag   = 4'd3;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    reset_n = 1'b0;
    tick();
    check_val("midrst_in_ready", int'(in_ready), 0, 0);
    check_val("midrst_angle", int'(out_angle), 0, 0);
    reset_n = 1'b1;
    seen = 0;
    repeat (25) begin
      tick();
      if (out_valid) seen++;
    end
    check_val("midrst_no_result", seen, 0, 0);
    run_sample(-700, 300, 9, ref_angle(-700, 300), 2, 0);

    for (int i = 0; i < 30; i++) begin
      do begin
        rx = int'($urandom_range(0, 65535)) - 32768;
        ry = int'($urandom_range(0, 65535)) - 32768;
      end while (rx > -1024 && rx < 1024 && ry > -1024 && ry < 1024);
      run_sample(rx, ry, int'($urandom_range(0, 15)), ref_angle(rx, ry), 2,
                 int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
